// File: rtl/regfile_bypass.sv
// 32 x WIDTH register file: two combinational read ports, one synchronous write port,
// synchronous clear, hardwired-zero register and optional same-cycle write-through.
module regfile_bypass #(
  parameter int WIDTH    = 64,
  parameter int ZERO_REG = 31,
  parameter bit BYPASS   = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ReadRegister1,
  input  logic [4:0]       ReadRegister2,
  input  logic [4:0]       WriteRegister,
  input  logic [WIDTH-1:0] WriteData,
  input  logic             RegWrite,
  output logic [WIDTH-1:0] ReadData1,
  output logic [WIDTH-1:0] ReadData2
);

  localparam logic [4:0] ZR = 5'(ZERO_REG);

  logic [31:0]      w_wdec;
  logic [WIDTH-1:0] w_stored [32];
  logic             w_byp1;
  logic             w_byp2;

  assign w_wdec = RegWrite ? (32'd1 << WriteRegister) : 32'd0;

  for (genvar i = 0; i < 32; i++) begin : g_reg
    if (i == ZERO_REG) begin : g_zero
      assign w_stored[i] = '0;
    end else begin : g_store
      logic [WIDTH-1:0] r_q;
      // Reset wins over a write presented in the same cycle.
      always_ff @(posedge clk) begin
        if (reset)
          r_q <= '0;
        else if (w_wdec[i])
          r_q <= WriteData;
      end
      assign w_stored[i] = r_q;
    end
  end

  // Forwarding is suppressed during reset so reads then reflect stored state only.
  assign w_byp1 = BYPASS && RegWrite && !reset && (WriteRegister != ZR) &&
                  (WriteRegister == ReadRegister1);
  assign w_byp2 = BYPASS && RegWrite && !reset && (WriteRegister != ZR) &&
                  (WriteRegister == ReadRegister2);

  always_comb begin
    ReadData1 = w_stored[ReadRegister1];
    ReadData2 = w_stored[ReadRegister2];
    if (w_byp1) ReadData1 = WriteData;
    if (w_byp2) ReadData2 = WriteData;
    if (ReadRegister1 == ZR) ReadData1 = '0;
    if (ReadRegister2 == ZR) ReadData2 = '0;
  end

endmodule

// File: tb/tb_regfile_bypass.sv
// Bench for regfile_bypass: a forwarding and a non-forwarding instance share inputs
// and are compared against an array-based reference model.
module tb_regfile_bypass;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rr1, rr2, wa;
  logic [63:0] wd;
  logic        we;
  logic [63:0] rd1_b, rd2_b, rd1_n, rd2_n;

  int vectors = 0;
  int miscompares = 0;
  logic [63:0] model [32];

  always #50 clk = ~clk;

  regfile_bypass #(.WIDTH(64), .ZERO_REG(31), .BYPASS(1'b1)) u_byp (
    .clk(clk), .reset(reset), .ReadRegister1(rr1), .ReadRegister2(rr2),
    .WriteRegister(wa), .WriteData(wd), .RegWrite(we),
    .ReadData1(rd1_b), .ReadData2(rd2_b)
  );

  regfile_bypass #(.WIDTH(64), .ZERO_REG(31), .BYPASS(1'b0)) u_nob (
    .clk(clk), .reset(reset), .ReadRegister1(rr1), .ReadRegister2(rr2),
    .WriteRegister(wa), .WriteData(wd), .RegWrite(we),
    .ReadData1(rd1_n), .ReadData2(rd2_n)
  );

  function automatic logic [63:0] ref_read(input logic [4:0] a, input bit byp);
    if (a == 5'd31) return 64'd0;
    if (byp && we && !reset && wa == a) return wd;
    return model[a];
  endfunction

  task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk(input string tag);
    #1;
    cmp({tag, "/b1"}, rd1_b, ref_read(rr1, 1'b1));
    cmp({tag, "/b2"}, rd2_b, ref_read(rr2, 1'b1));
    cmp({tag, "/n1"}, rd1_n, ref_read(rr1, 1'b0));
    cmp({tag, "/n2"}, rd2_n, ref_read(rr2, 1'b0));
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) begin
      for (int k = 0; k < 32; k++) model[k] = 64'd0;
    end else if (we && wa != 5'd31) begin
      model[wa] = wd;
    end
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [63:0] d);
    reset = 1'b0; we = 1'b1; wa = a; wd = d;
    tick();
    we = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 32; k++) model[k] = 64'd0;
    reset = 1'b1; we = 1'b0; wa = 5'd0; wd = 64'd0; rr1 = 5'd0; rr2 = 5'd30;
    tick();
    reset = 1'b0;
    #1;
    cmp("rst_x0", rd1_b, 64'd0);
    cmp("rst_x30", rd2_n, 64'd0);

    // Reset clears stored data and discards a write in the reset cycle
    wr(5'd5, 64'hDEADBEEF_CAFEF00D);
    rr1 = 5'd5; rr2 = 5'd30;
    #1;
    cmp("x5_written", rd1_n, 64'hDEADBEEF_CAFEF00D);
    reset = 1'b1; we = 1'b1; wa = 5'd6; wd = 64'h0123_4567_89AB_CDEF;
    tick();
    reset = 1'b0; we = 1'b0;
    #1;
    cmp("clr_x5", rd1_b, 64'd0);
    cmp("clr_x30", rd2_b, 64'd0);
    rr1 = 5'd6;
    #1;
    cmp("rst_write_dropped", rd1_n, 64'd0);

    // Write every register, then read complementary pairs
    for (int i = 0; i <= 30; i++) wr(5'(i), {32'hA5A5_0000, 32'(i)});
    for (int i = 0; i <= 30; i++) begin
      rr1 = 5'(i); rr2 = 5'(30 - i);
      #1;
      cmp("pair_p1", rd1_b, {32'hA5A5_0000, 32'(i)});
      cmp("pair_p2", rd2_n, {32'hA5A5_0000, 32'(30 - i)});
      chk("pair");
    end
    rr1 = 5'd31; rr2 = 5'd31;
    #1;
    cmp("x31_p1", rd1_b, 64'd0);
    cmp("x31_p2", rd2_n, 64'd0);

    // Zero register ignores writes and never forwards
    we = 1'b1; wa = 5'd31; wd = '1;
    #1;
    cmp("zr_pre_b", rd1_b, 64'd0);
    cmp("zr_pre_n", rd2_b, 64'd0);
    tick();
    we = 1'b0;
    #1;
    cmp("zr_post", rd1_b, 64'd0);
    for (int i = 0; i < 32; i++) begin
      rr1 = 5'(i); rr2 = 5'(31 - i);
      chk("zr_scan");
    end

    // Write-enable gating
    wr(5'd7, 64'h0000_0000_0000_00A7);
    we = 1'b0; wa = 5'd7; wd = 64'h1234; rr1 = 5'd7; rr2 = 5'd7;
    for (int n = 0; n < 3; n++) begin
      tick();
      cmp("gate_x7", rd1_b, 64'hA7);
      cmp("gate_x7_n", rd2_n, 64'hA7);
    end

    // Same-cycle forwarding
    wr(5'd9, 64'h11);
    we = 1'b1; wa = 5'd9; wd = 64'h22; rr1 = 5'd9; rr2 = 5'd10;
    #1;
    cmp("byp_pre_b", rd1_b, 64'h22);
    cmp("byp_pre_n", rd1_n, 64'h11);
    cmp("byp_x10_b", rd2_b, {32'hA5A5_0000, 32'd10});
    cmp("byp_x10_n", rd2_n, {32'hA5A5_0000, 32'd10});
    tick();
    we = 1'b0;
    #1;
    cmp("byp_post_b", rd1_b, 64'h22);
    cmp("byp_post_n", rd1_n, 64'h22);

    // Reset suppresses forwarding
    wr(5'd3, 64'h55);
    reset = 1'b1; we = 1'b1; wa = 5'd3; wd = 64'h99; rr1 = 5'd3; rr2 = 5'd3;
    #1;
    cmp("rb_pre_b", rd1_b, 64'h55);
    cmp("rb_pre_n", rd1_n, 64'h55);
    tick();
    #1;
    cmp("rb_post_b", rd1_b, 64'd0);
    cmp("rb_post_n", rd2_n, 64'd0);
    reset = 1'b0; we = 1'b0;

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 24) == 0);
      we    = 1'($urandom);
      wa    = 5'($urandom_range(0, 31));
      wd    = {$urandom, $urandom};
      rr1   = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
      rr2   = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
      chk("rand");
      tick();
    end
    reset = 1'b0; we = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rr1 = 5'(i); rr2 = 5'(i);
      chk("final_scan");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile_bypass.md
Name: regfile_bypass

Overview:
- 32-entry × 64-bit ARM register file with two asynchronous read ports and one synchronous write port.
- Sits in the decode stage of the 5-stage pipeline. It is fed by the write-back stage (write port) and feeds the ID/EX pipeline register (read ports).
- Built from per-register write-enabled 64-bit storage elements, a 5-to-32 write decoder, and two 32:1 read muxes.
- Adds a synchronous clear, a hardwired-zero X31, and an optional write-through bypass that resolves the WB→ID same-cycle hazard.

Parameters:
- WIDTH, 64, data width of each register and of the read/write data ports.
- ZERO_REG, 31, index of the register that always reads 0 and ignores writes.
- BYPASS, 1, 1 = a same-cycle write is forwarded to a matching read port; 0 = reads return the pre-edge stored value.

Ports:
- clk  input  1  sole clock; all state updates on posedge.
- reset  input  1  synchronous, active-high; clears all registers on posedge clk while high.
- ReadRegister1  input  5  read port 1 address.
- ReadRegister2  input  5  read port 2 address.
- WriteRegister  input  5  write port address.
- WriteData  input  WIDTH  write data.
- RegWrite  input  1  write enable, sampled on posedge clk.
- ReadData1  output  WIDTH  read port 1 data.
- ReadData2  output  WIDTH  read port 2 data.

Behaviour:
- Storage: 31 writable registers (indices 0..30 with ZERO_REG excluded). The ZERO_REG index has no storage.
- Reset:
  - On posedge clk with reset=1, every stored register becomes 0.
  - Reset has priority over RegWrite; a write presented in the reset cycle is discarded.
  - After reset, both read ports return 0 for every address.
  - Asserting reset mid-operation clears all state at the next edge; no partial clear.
- Write:
  - On posedge clk with reset=0 and RegWrite=1, register[WriteRegister] ← WriteData.
  - Exactly one register changes; all others hold their value.
  - RegWrite=0 leaves all registers unchanged.
  - WriteRegister==ZERO_REG is a no-op.
- Read:
  - Combinational from address to data; zero cycles of latency.
  - ReadRegisterN==ZERO_REG always returns 0, regardless of any write or bypass.
  - Both ports may address the same register and then return identical data.
- Bypass (BYPASS=1):
  - Condition: RegWrite=1, reset=0, WriteRegister==ReadRegisterN, and WriteRegister!=ZERO_REG.
  - When the condition holds, ReadDataN = WriteData combinationally in the same cycle, before the edge.
  - The bypass applies to both ports independently.
- Bypass disabled (BYPASS=0): ReadDataN shows the new value only after the write edge.
- Reset/bypass interaction: while reset=1, bypass is suppressed and reads show stored values. Those are zero from the first reset edge onward.
- Undriven or X address inputs are outside spec; the bench must not apply them.

Test Plan:
- Reset clear: write 0xDEADBEEF_CAFEF00D to X5, then reset=1 for 1 cycle, then read X5 and X30 → both 0; WriteData presented with RegWrite=1 in the reset cycle → not stored.
- Write/read all: write value {32'hA5A5_0000, i} to Xi for i=0..30 on consecutive cycles, then read every pair (i, 30-i) → exact values on both ports; X31 → 0.
- Zero register: RegWrite=1, WriteRegister=31, WriteData=all-ones → ReadData1/2 at address 31 = 0 both before and after the edge; no other register changes.
- Write-enable gating: RegWrite=0 with WriteRegister=7, WriteData=0x1234 → X7 keeps its previous value 0x00000000_000000A7 across 3 edges.
- Bypass: X9 holds 0x11, present RegWrite=1, WriteRegister=9, WriteData=0x22, ReadRegister1=9, ReadRegister2=10 → before the edge ReadData1=0x22 (BYPASS=1) or 0x11 (BYPASS=0), ReadData2 = X10 unchanged; after the edge ReadData1=0x22 in both configs.
- Simultaneous reset and bypass: reset=1, RegWrite=1, WriteRegister=3, ReadRegister1=3, X3=0x55 → ReadData1 shows 0x55 before the edge and 0 after it, never 0x WriteData.
